// File: rtl/imem_loader.sv
// imem_loader: boot/reload controller that streams a program image into the
// core's instruction memory and holds the core in reset until the image has
// been written and a fixed hold window has elapsed.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load_start      single-cycle load request; load_len sampled with it
//   load_len        payload length in words (1 .. 2^ADDR_WIDTH)
//   s_valid/s_data  input word stream, s_ready is the accept strobe
//   imem_wr_en      imem write strobe, with imem_addr / imem_data_in
//   core_rst        reset to the core, active high
//   busy            high in LOAD, CHECK and HOLD
//   done            one-cycle pulse when core_rst is released after a load
//   error           sticky; cleared by rst or an accepted load_start
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When defined, one extra
// stream word after the payload is taken as a modulo-2^DATA_WIDTH checksum of
// the payload; a mismatch flags error and returns to BOOT.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  imem_wr_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_data_in,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD - 1);
  // Largest legal length is exactly 2^ADDR_WIDTH (fills the whole memory).
  localparam logic [ADDR_WIDTH:0] MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    StBoot,
    StLoad,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StHold,
    StRun
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [HoldW-1:0]      hold_q, hold_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  core_rst_q, core_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  logic len_ok;
  logic last_word;
  logic hs;

  assign len_ok    = (load_len != '0) && (load_len <= MaxLen);
  assign last_word = (cnt_q == len_q - 1'b1);
  assign hs        = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    hold_d  = hold_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    done_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    s_ready = (state_q == StLoad) || (state_q == StCheck);
`else
    s_ready = (state_q == StLoad);
`endif

    unique case (state_q)
      StBoot, StRun: begin
        if (load_start) begin
          if (len_ok) begin
            len_d   = load_len;
            cnt_d   = '0;
            err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
            state_d = StLoad;
          end else begin
            // Bad length: flag it and park the core in reset.
            err_d   = 1'b1;
            state_d = StBoot;
          end
        end
      end
      StLoad: begin
        if (hs) begin
          wr_d   = 1'b1;
          addr_d = cnt_q[ADDR_WIDTH-1:0];
          data_d = s_data;
          cnt_d  = cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + s_data;
`endif
          if (last_word) begin
            hold_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StHold;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        // Checksum word is consumed but never written to imem.
        if (hs) begin
          if (s_data == sum_q) begin
            hold_d  = '0;
            state_d = StHold;
          end else begin
            err_d   = 1'b1;
            state_d = StBoot;
          end
        end
      end
`endif
      StHold: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StBoot;
    endcase

    // Core runs only in RUN; registering from state_d gives the one-cycle
    // delayed assertion after an accepted load_start.
    core_rst_d = (state_d != StRun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      cnt_q      <= '0;
      len_q      <= '0;
      hold_q     <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      hold_q     <= hold_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign imem_wr_en   = wr_q;
  assign imem_addr    = addr_q;
  assign imem_data_in = data_q;
  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign error        = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign busy = (state_q == StLoad) || (state_q == StCheck) || (state_q == StHold);
`else
  assign busy = (state_q == StLoad) || (state_q == StHold);
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: scoreboard of expected imem writes (pushed when a
// word is driven, popped when the write strobe appears), plus direct checks
// of reset, release timing, length errors and mid-load reset.
module tb_imem_loader;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned RH = 4;
  localparam int MaxLen = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int RelLat = RH + 1;
`else
  localparam int RelLat = RH;
`endif

  logic          clk;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          imem_wr_en;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data_in;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          error;

  imem_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_HOLD (RH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_len     (load_len),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_addr    (imem_addr),
    .imem_data_in (imem_data_in),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } wr_t;

  wr_t           sb[$];
  wr_t           mon_e;
  logic [DW-1:0] payload[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            last_wr_cyc = 0;
  int            done_cnt = 0;
  int            exp_done = 0;
  int            exp_cnt = 0;
  logic [DW-1:0] exp_sum = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("wr_unexpected", imem_wr_en, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("wr_addr", imem_addr, mon_e.addr);
        check_eq("wr_data", imem_data_in, mon_e.data);
        check_eq("wr_latency", cyc, mon_e.due);
      end
      last_wr_cyc = cyc;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic start_load(input int len);
    logic [31:0] l;
    l = len;
    @(posedge clk); #1;
    s_valid    = 1'b0;
    load_start = 1'b1;
    load_len   = l[AW:0];
    @(posedge clk); #1;
    load_start = 1'b0;
    if (len != 0 && len <= MaxLen) begin
      exp_cnt = 0;
      exp_sum = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    wr_t e;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    check_eq("s_ready_load", s_ready, 1'b1);
    e.addr = exp_cnt[AW-1:0];
    e.data = d;
    e.due  = cyc + 1;
    sb.push_back(e);
    exp_cnt++;
    exp_sum = exp_sum + d;
  endtask

  // Optional checksum word, then offer a stray word that must not be taken.
  task automatic finish_payload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = exp_sum;
    @(negedge clk);
    check_eq("s_ready_check", s_ready, 1'b1);
`endif
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("s_ready_after_last", s_ready, 1'b0);
    check_eq("busy_hold", busy, 1'b1);
    check_eq("core_rst_hold", core_rst, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_release();
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (core_rst === 1'b0) seen = 1'b1;
    end
    check_eq("release_seen", seen, 1'b1);
    if (seen) begin
      exp_done++;
      check_eq("release_lat", cyc - last_wr_cyc, RelLat);
      check_eq("done_pulse", done, 1'b1);
      check_eq("busy_run", busy, 1'b0);
      @(negedge clk);
      check_eq("done_one_cycle", done, 1'b0);
      check_eq("core_rst_run", core_rst, 1'b0);
    end
  endtask

  task automatic run_payload(input bit toggle);
    start_load(payload.size());
    @(negedge clk);
    check_eq("busy_load", busy, 1'b1);
    check_eq("core_rst_load", core_rst, 1'b1);
    check_eq("error_cleared", error, 1'b0);
    check_eq("s_ready_first", s_ready, 1'b1);
    foreach (payload[i]) begin
      if (toggle && i > 0) idle(1);
      send_word(payload[i]);
    end
    finish_payload();
    wait_release();
    check_eq("sb_drain", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset: core held, nothing moves.
    @(negedge clk);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_addr", imem_addr, '0);
    check_eq("rst_data", imem_data_in, '0);
    for (int i = 0; i < 10; i++) begin
      check_eq("idle_core_rst", core_rst, 1'b1);
      check_eq("idle_s_ready", s_ready, 1'b0);
      check_eq("idle_wr_en", imem_wr_en, 1'b0);
      check_eq("idle_busy", busy, 1'b0);
      @(negedge clk);
    end

    // Back-to-back three-instruction program.
    payload = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};
    run_payload(1'b0);

    // Same program with a gap between words.
    run_payload(1'b1);

    // load_start during LOAD is ignored.
    start_load(2);
    send_word(32'hCAFE_0001);
    @(posedge clk); #1;
    s_valid    = 1'b0;
    load_start = 1'b1;
    load_len   = '0;
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk);
    check_eq("ignore_error", error, 1'b0);
    check_eq("ignore_busy", busy, 1'b1);
    send_word(32'hCAFE_0002);
    finish_payload();
    wait_release();
    check_eq("sb_drain_ignore", sb.size(), 0);

    // Zero length from RUN: error and back to BOOT.
    start_load(0);
    @(negedge clk);
    check_eq("len0_error", error, 1'b1);
    check_eq("len0_core_rst", core_rst, 1'b1);
    check_eq("len0_busy", busy, 1'b0);
    check_eq("len0_s_ready", s_ready, 1'b0);
    idle(3);
    @(negedge clk);
    check_eq("boot_hold_core_rst", core_rst, 1'b1);
    check_eq("boot_hold_busy", busy, 1'b0);
    check_eq("boot_error_sticky", error, 1'b1);

    // Oversize length from BOOT stays in BOOT.
    start_load(MaxLen + 1);
    @(negedge clk);
    check_eq("oversize_error", error, 1'b1);
    check_eq("oversize_busy", busy, 1'b0);

    // Valid load clears error.
    payload = '{32'h1111_2222, 32'h3333_4444};
    run_payload(1'b0);

    // Reset after two of five words.
    start_load(5);
    send_word(32'hA5A5_0000);
    send_word(32'hA5A5_0001);
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_wr_en", imem_wr_en, 1'b0);
    check_eq("midrst_core_rst", core_rst, 1'b1);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_s_ready", s_ready, 1'b0);
    check_eq("sb_drain_midrst", sb.size(), 0);
    payload = '{32'h0000_0AAA, 32'h0000_0BBB, 32'h0000_0CCC};
    run_payload(1'b0);

    // Single word, then a full-capacity image up to the top address.
    payload = '{32'h1234_5678};
    run_payload(1'b0);
    payload.delete();
    for (int i = 0; i < MaxLen; i++) payload.push_back(32'h9E37_79B9 * i + 32'h5);
    run_payload(1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good checksum (0x3) releases the core.
    payload = '{32'h1, 32'h2};
    run_payload(1'b0);

    // Bad checksum (0x4): error, core stays in reset, no done.
    start_load(2);
    send_word(32'h1);
    send_word(32'h2);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 32'h4;
    @(negedge clk);
    check_eq("bad_sum_s_ready", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check_eq("bad_sum_error", error, 1'b1);
    check_eq("bad_sum_core_rst", core_rst, 1'b1);
    check_eq("bad_sum_busy", busy, 1'b0);
    idle(RH + 3);
    @(negedge clk);
    check_eq("bad_sum_core_rst_late", core_rst, 1'b1);
    check_eq("sb_drain_bad_sum", sb.size(), 0);
`endif

    idle(2);
    check_eq("done_count", done_cnt, exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time/reload controller that sequences writes into the core's instruction memory from a valid/ready word stream.
- Holds the risc_v core in reset while loading. Releases it only after the program image is fully written plus a fixed reset-hold window.
- Sits between the host/UART receive path and the core's imem write port: drives imem_wr_en, the write address and imem_data_in, plus the core's reset.

Parameters:
- ADDR_WIDTH, 10, imem word-address width; capacity is 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width.
- RESET_HOLD, 4, cycles core_rst stays high after the last imem write; minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- load_start  input  1  single-cycle request to begin a load
- load_len  input  ADDR_WIDTH+1  number of payload words; sampled with load_start
- s_valid  input  1  stream word valid
- s_data  input  DATA_WIDTH  stream word
- s_ready  output  1  loader accepts s_data this cycle
- imem_wr_en  output  1  imem write strobe
- imem_addr  output  ADDR_WIDTH  imem word address
- imem_data_in  output  DATA_WIDTH  imem write data
- core_rst  output  1  reset to the risc_v core, active high
- busy  output  1  high in any state other than IDLE/RUN
- done  output  1  one-cycle pulse when core_rst deasserts after a load
- error  output  1  sticky; cleared only by rst or an accepted load_start

Behaviour:
- Single clock domain: clk. rst is synchronous and active-high.
- States: BOOT, LOAD, CHECK (feature only), HOLD, RUN.
- On reset:
  - state=BOOT, core_rst=1, s_ready=0, imem_wr_en=0.
  - imem_addr=0, imem_data_in=0, busy=0, done=0, error=0.
- BOOT: core held in reset indefinitely until load_start is accepted.
- load_start accepted only in BOOT or RUN:
  - Latch load_len, clear error, clear word counter, go to LOAD.
  - core_rst goes high the cycle after acceptance (both BOOT and RUN).
- load_start in LOAD/CHECK/HOLD: ignored; no state change.
- Invalid length (load_len==0 or load_len>2^ADDR_WIDTH):
  - error=1, no write.
  - From BOOT, stay in BOOT. From RUN, go to BOOT (core held in reset).
- LOAD:
  - s_ready=1.
  - A handshake (s_valid&&s_ready) in cycle t produces, registered in t+1: imem_wr_en=1, imem_addr=counter, imem_data_in=s_data. Counter then increments.
  - imem_wr_en=0 in any cycle following a non-handshake cycle.
  - Write latency: exactly 1 cycle from handshake.
  - Addresses run 0..load_len-1. A load_len of 2^ADDR_WIDTH writes up to the top address; the counter never wraps past it.
  - s_ready drops the cycle after the last payload word is accepted. No further words are consumed.
- Without the feature, LOAD goes to HOLD after the last word.
- HOLD:
  - Counts RESET_HOLD cycles starting the cycle after the last write strobe, with core_rst=1.
  - Then core_rst=0, done=1 for one cycle, state=RUN.
- RUN: core_rst=0, busy=0. The loader is passive until load_start.
- busy=1 in LOAD, CHECK and HOLD.
- rst in any state (including mid-LOAD): immediate return to BOOT.
  - Partially written imem contents are left as-is.
  - core_rst=1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - During LOAD, keep a DATA_WIDTH modulo-2^32 running sum of accepted payload words.
  - After the last payload word, enter CHECK with s_ready=1. Accept one extra stream word as the expected checksum; it is not written to imem.
  - Match: go to HOLD.
  - Mismatch: error=1, go to BOOT, core stays in reset, no done.
- Undefined: no CHECK state, no adder. The word after the payload is not consumed (s_ready=0).

Test Plan:
- Reset then idle 10 cycles -> core_rst=1, s_ready=0, imem_wr_en=0, busy=0 throughout.
- load_start with load_len=3, stream 0x00500093, 0x00100113, 0x002081B3 back-to-back:
  - imem_wr_en high for 3 consecutive cycles, addr 0,1,2 with matching data, each 1 cycle after its handshake.
  - core_rst falls exactly RESET_HOLD=4 cycles after the last strobe; done pulses once in the same cycle.
- Same load with s_valid toggling 1,0,1,0,1 -> writes only on handshake cycles, addresses contiguous 0..2, no duplicate strobes.
- load_len=0 from RUN -> error=1, core_rst=1 next cycle, state BOOT, zero writes. Then a valid load_start clears error.
- rst asserted after 2 of 5 words -> next cycle BOOT, imem_wr_en=0, core_rst=1, counter restarts at 0 on the next load.
- With IMEM_LOADER_CHECKSUM_EN, load_len=2, words 0x1, 0x2:
  - Checksum 0x3 -> core released, done=1.
  - Checksum 0x4 -> error=1, core_rst stays 1, no done.
